booth_mac_accumulator: RTL

//  Sequential dot-product stage built around the 16-bit BoothMultiplier(result, x, y).

---
 rtl/booth_mac_accumulator.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/booth_mac_accumulator.sv
// booth_mac_accumulator: streaming unsigned 16x16 multiply-accumulate stage.
// Accepts operand beats over valid/ready. It returns one ACC_W-bit sum per vector,
// together with a saturating beat count and a sticky overflow flag.
// Build option: define BOOTH_MAC_SATURATE_EN to clamp the accumulator to all-ones
// on overflow. Without it, the accumulator wraps modulo 2^ACC_W.

module BoothMultiplier (
  output logic [31:0] result,
  input  logic [15:0] x,
  input  logic [15:0] y
);
  logic [35:0] mcand;
  logic [18:0] ybits;
  logic [35:0] pp;
  logic [35:0] psum;

  // Radix-4 Booth recoding over the zero-extended multiplier. Signed partial
  // products wrap mod 2^36, and the true product is < 2^32.
  always_comb begin
    mcand = {20'b0, x};
    ybits = {2'b00, y, 1'b0};
    pp    = '0;
    psum  = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      case (ybits[2*i +: 3])
        3'b001, 3'b010: pp = mcand;
        3'b011:         pp = mcand << 1;
        3'b100:         pp = -(mcand << 1);
        3'b101, 3'b110: pp = -mcand;
        default:        pp = '0;
      endcase
      psum = psum + (pp << (2*i));
    end
    result = psum[31:0];
  end
endmodule

module booth_mac_accumulator #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_x,
  input  logic [15:0]      in_y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [LEN_W-1:0] out_count,
  output logic             out_overflow
);
  typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_t;

  state_t             state_q, state_d;
  logic               s1_valid_q, s1_last_q;
  logic [15:0]        s1_x_q, s1_y_q;
  logic [31:0]        prod;
  logic [ACC_W:0]     sum_ext;
  logic               carry;
  logic [ACC_W-1:0]   acc_q, acc_d, osum_q, osum_d;
  logic [LEN_W-1:0]   count_q, count_d, ocnt_q, ocnt_d;
  logic               ovf_q, ovf_d, oovf_q, oovf_d;
  logic               accept;

  BoothMultiplier u_mult (
    .result (prod),
    .x      (s1_x_q),
    .y      (s1_y_q)
  );

  assign accept       = in_valid && in_ready;
  assign out_sum      = osum_q;
  assign out_count    = ocnt_q;
  assign out_overflow = oovf_q;

  // FSM next state and handshake outputs; in_ready never looks at in_valid.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = !reset;
        if (in_valid && !reset && in_last) state_d = FLUSH;
      end
      FLUSH: state_d = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Stage-2 accumulate, saturating count, sticky overflow and result capture.
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    osum_d  = osum_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    sum_ext = {1'b0, acc_q} + {{(ACC_W-31){1'b0}}, prod};
    carry   = sum_ext[ACC_W];
    if (s1_valid_q) begin
      acc_d = sum_ext[ACC_W-1:0];
`ifdef BOOTH_MAC_SATURATE_EN
      if (carry) acc_d = '1;
`endif
      count_d = (count_q == '1) ? count_q : count_q + LEN_W'(1);
      ovf_d   = ovf_q | carry;
      if (s1_last_q) begin
        osum_d = acc_d;
        ocnt_d = count_d;
        oovf_d = ovf_d;
      end
    end
    if (out_valid && out_ready) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  // Stage-1 operand register loaded on each accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q <= in_last;
        s1_x_q    <= in_x;
        s1_y_q    <= in_y;
      end
    end
  end

  // Accumulator and held-result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      osum_q  <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      osum_q  <= osum_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end
endmodule
